// File: rtl/event_pkg.sv
// Shared types and constants for the event encoder and its priority picker.
package event_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    localparam int              DROP_W   = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = 8'hFF;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/pick_first.sv
// Finds the first set bit of i_vec, searching upward from i_start_ptr and
// wrapping from N-1 back to 0.
module pick_first #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_vec,
    input  logic [IDX_W-1:0] i_start_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    logic [IDX_W-1:0] w_pos;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_pos   = '0;
        for (int off = 0; off < N; off++) begin
            w_pos = IDX_W'((int'(i_start_ptr) + off) % N);
            if (!o_found && i_vec[w_pos]) begin
                o_found = 1'b1;
                o_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/event_encoder.sv
// Captures event pulses into a pending register and presents one binary index
// at a time over a valid/ready handshake (fixed priority or round-robin).
module event_encoder
    import event_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int RR    = 0,
    localparam int IDX_W = clog2(N)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic [N-1:0]      i_req,
    output logic [IDX_W-1:0]  o_out_idx,
    output logic [N-1:0]      o_out_onehot,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [N-1:0]      o_pending,
    output logic [DROP_W-1:0] o_drop_cnt
);

    state_e            r_state;
    state_e            w_state_next;
    logic [N-1:0]      r_pending;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_ptr;
    logic [DROP_W-1:0] r_drop_cnt;

    logic [IDX_W-1:0]  w_start;
    logic [IDX_W-1:0]  w_sel_idx;
    logic              w_found;
    logic              w_load;
    logic [N-1:0]      w_clr;
    logic [N-1:0]      w_set;
    logic [N-1:0]      w_pending_next;
    logic              w_drop;

    assign w_start = (RR != 0) ? r_ptr : '0;

    pick_first #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_vec       (r_pending),
        .i_start_ptr (w_start),
        .o_idx       (w_sel_idx),
        .o_found     (w_found)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_load       = 1'b1;
                    w_state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (i_out_ready) begin
                    if (w_found) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Set wins over clear, so a request on the bit being loaded re-pends it.
    assign w_clr          = w_load ? (N'(1) << w_sel_idx) : '0;
    assign w_set          = i_req & {N{i_en}};
    assign w_pending_next = (r_pending & ~w_clr) | w_set;
    assign w_drop         = |(w_set & r_pending & ~w_clr);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending  <= '0;
            r_idx      <= '0;
            r_ptr      <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_pending <= w_pending_next;
            if (w_load) begin
                r_idx <= w_sel_idx;
                r_ptr <= (w_sel_idx == IDX_W'(N - 1)) ? '0 : w_sel_idx + IDX_W'(1);
            end
            if (w_drop && (r_drop_cnt != DROP_MAX)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    assign o_out_valid  = (r_state == PRESENT);
    assign o_out_idx    = r_idx;
    assign o_out_onehot = o_out_valid ? (N'(1) << r_idx) : '0;
    assign o_pending    = r_pending;
    assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_event_encoder.sv
// Directed bench: a fixed-priority and a round-robin encoder share one stimulus.
module tb_event_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       out_ready;
    logic [7:0] req;

    logic [2:0] fp_idx,     rr_idx;
    logic [7:0] fp_onehot,  rr_onehot;
    logic       fp_valid,   rr_valid;
    logic [7:0] fp_pending, rr_pending;
    logic [7:0] fp_drop,    rr_drop;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_rr[4] = '{1, 6, 1, 6};

    always #5 clk = ~clk;

    event_encoder #(.N(8), .RR(0)) dut_fp (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_en         (en),
        .i_req        (req),
        .o_out_idx    (fp_idx),
        .o_out_onehot (fp_onehot),
        .o_out_valid  (fp_valid),
        .i_out_ready  (out_ready),
        .o_pending    (fp_pending),
        .o_drop_cnt   (fp_drop)
    );

    event_encoder #(.N(8), .RR(1)) dut_rr (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_en         (en),
        .i_req        (req),
        .o_out_idx    (rr_idx),
        .o_out_onehot (rr_onehot),
        .o_out_valid  (rr_valid),
        .i_out_ready  (out_ready),
        .o_pending    (rr_pending),
        .o_drop_cnt   (rr_drop)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic [7:0] r);
        req = r;
        @(posedge clk);
        #1;
        req = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(8'h00);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        en        = 1'b1;
        out_ready = 1'b0;
        req       = 8'h00;
        do_reset();

        check("rst_valid",   32'(fp_valid),   0);
        check("rst_idx",     32'(fp_idx),     0);
        check("rst_onehot",  32'(fp_onehot),  0);
        check("rst_pending", 32'(fp_pending), 0);
        check("rst_drop",    32'(fp_drop),    0);
        check("rst_rr_idx",  32'(rr_idx),     0);

        // Single event
        out_ready = 1'b1;
        cycle(8'b0001_0000);
        check("single_pend",   32'(fp_pending), 32'h10);
        check("single_v0",     32'(fp_valid),   0);
        cycle(8'h00);
        check("single_valid",  32'(fp_valid),   1);
        check("single_idx",    32'(fp_idx),     4);
        check("single_onehot", 32'(fp_onehot),  32'h10);
        cycle(8'h00);
        check("single_done_v", 32'(fp_valid),   0);
        check("single_done_p", 32'(fp_pending), 0);
        check("single_done_oh",32'(fp_onehot),  0);

        // Fixed-priority backlog
        cycle(8'b1000_0101);
        cycle(8'h00);
        check("fp_idx0", 32'(fp_idx), 0);
        check("fp_v0",   32'(fp_valid), 1);
        cycle(8'h00);
        check("fp_idx1", 32'(fp_idx), 2);
        check("fp_v1",   32'(fp_valid), 1);
        cycle(8'h00);
        check("fp_idx2", 32'(fp_idx), 7);
        check("fp_oh2",  32'(fp_onehot), 32'h80);
        cycle(8'h00);
        check("fp_end_v", 32'(fp_valid), 0);

        // Round-robin vs fixed priority with bits 1 and 6 always re-requested
        do_reset();
        out_ready = 1'b1;
        cycle(8'h42);
        for (int i = 0; i < 4; i++) begin
            cycle(8'h42);
            check($sformatf("rr_idx%0d", i), 32'(rr_idx), exp_rr[i]);
            check($sformatf("rr_fp_idx%0d", i), 32'(fp_idx), 1);
            if (i == 0) begin
                check("rr_repend", 32'(rr_pending), 32'h42);
            end
        end

        // Backpressure and drops
        do_reset();
        out_ready = 1'b0;
        cycle(8'h08);
        cycle(8'h20);
        cycle(8'h20);
        check("bp_idx",     32'(fp_idx),     3);
        check("bp_valid",   32'(fp_valid),   1);
        check("bp_pending", 32'(fp_pending), 32'h20);
        check("bp_drop",    32'(fp_drop),    1);
        cycle(8'h00);
        check("bp_hold",    32'(fp_idx),     3);
        out_ready = 1'b1;
        cycle(8'h00);
        check("bp_rel_idx", 32'(fp_idx),     5);
        check("bp_rel_v",   32'(fp_valid),   1);
        check("bp_rel_p",   32'(fp_pending), 0);
        cycle(8'h00);
        check("bp_end_v",   32'(fp_valid),   0);
        out_ready = 1'b0;
        cycle(8'h10);
        cycle(8'h00);
        cycle(8'h10);
        check("held_repend", 32'(fp_pending), 32'h10);
        check("held_nodrop", 32'(fp_drop),    1);

        // Enable gating and drop saturation
        do_reset();
        out_ready = 1'b0;
        cycle(8'h01);
        cycle(8'h02);
        en = 1'b0;
        repeat (3) cycle(8'hFF);
        check("en0_pending", 32'(fp_pending), 32'h02);
        check("en0_drop",    32'(fp_drop),    0);
        check("en0_idx",     32'(fp_idx),     0);
        en = 1'b1;
        repeat (254) cycle(8'h02);
        check("drop_254", 32'(fp_drop), 254);
        repeat (46) cycle(8'h02);
        check("drop_sat", 32'(fp_drop), 255);

        // Reset mid-handshake
        do_reset();
        out_ready = 1'b0;
        cycle(8'h02);
        cycle(8'h0C);
        cycle(8'h04);
        check("pre_rst_v",    32'(fp_valid),   1);
        check("pre_rst_idx",  32'(fp_idx),     1);
        check("pre_rst_p",    32'(fp_pending), 32'h0C);
        check("pre_rst_drop", 32'(fp_drop),    1);
        do_reset();
        check("mid_rst_v",    32'(fp_valid),   0);
        check("mid_rst_p",    32'(fp_pending), 0);
        check("mid_rst_drop", 32'(fp_drop),    0);
        check("mid_rst_idx",  32'(fp_idx),     0);
        check("mid_rst_oh",   32'(fp_onehot),  0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
